capture_sequencer: RTL and testbench
====================================

# capture_sequencer

Sequences frame capture from the camera pixel stream into a frame-buffer write port. Arms on a software START, aligns to the next frame boundary, gates pixels, and issues linear-address writes. Supports single-shot or continuous capture with frame decimation, reports completion and overflow, and sits between the camera front end and the memory writer.

## Interface
- H, 752, active columns per line
- V, 480, active lines per frame
- AW, $clog2(H*V), write address width
- PIXCLK  in  1  pixel clock; all logic on rising edge
- RST_N  in  1  reset, synchronous, active-low
- FRAME_VALID  in  1  raw sensor frame strobe
- PIXEL_VALID  in  1  pixel qualifier, co-timed with DATA_IN/CURRENT_LINE/CURRENT_COLUMN
- DATA_IN  in  10  pixel value
- CURRENT_LINE  in  $clog2(V)  line index of current pixel
- CURRENT_COLUMN  in  $clog2(H)  column index of current pixel
- START  in  1  one-cycle capture request
- CONTINUOUS  in  1  level; re-evaluated at each frame end
- DECIMATE  in  4  frames skipped between captures in continuous mode
- ABORT  in  1  one-cycle cancel
- ROI_X0, ROI_X1  in  $clog2(H) each  inclusive column window (ROI build only)
- ROI_Y0, ROI_Y1  in  $clog2(V) each  inclusive line window (ROI build only)
- WR_READY  in  1  memory writer can accept this cycle
- WR_EN  out  1  write strobe
- WR_ADDR  out  AW  linear write address
- WR_DATA  out  10  write data
- BUSY  out  1  state != IDLE
- FRAME_DONE  out  1  one-cycle pulse per completed capture
- FRAME_COUNT  out  16  completed captures, wraps at 2^16
- OVERFLOW  out  1  sticky: a write was dropped

## Operation
- Reset: state IDLE; WR_EN, FRAME_DONE, OVERFLOW, BUSY = 0; FRAME_COUNT = 0; WR_ADDR = 0; WR_DATA = 0; internal prev_fv = 1 (a frame in progress at reset is not seen as a rise).
- Edges: rise = FRAME_VALID && !prev_fv; fall = !FRAME_VALID && prev_fv.
- IDLE: START -> ARMED; OVERFLOW cleared. START in any other state is ignored.
- ARMED: rise -> CAPTURE; address counter = 0.
- CAPTURE: a pixel is accepted when PIXEL_VALID=1 and in-window. An accepted pixel produces WR_EN, WR_DATA=DATA_IN, and WR_ADDR=counter, then the counter increments. On fall: FRAME_DONE pulse, FRAME_COUNT+1, then:
  - CONTINUOUS=0 -> IDLE
  - CONTINUOUS=1, DECIMATE=0 -> ARMED
  - otherwise -> SKIP, with skip_cnt = DECIMATE
- SKIP: each fall decrements skip_cnt; the fall at which skip_cnt==1 -> ARMED. DECIMATE=N captures every (N+1)th frame.
- ABORT (any state): next state IDLE, no FRAME_DONE, FRAME_COUNT unchanged. ABORT wins over START in the same cycle.
- Backpressure: WR_EN=1 with WR_READY=0 drops the pixel and sets OVERFLOW. The address still increments, so image geometry is preserved. OVERFLOW holds until the next accepted START or reset.
- The address counter saturates at H*V-1 and never wraps within a frame.

## Timing
- Write latency: pixel accepted in cycle n -> WR_EN/WR_ADDR/WR_DATA registered, valid in cycle n+1. WR_READY is sampled in that same n+1 cycle.
- Fall sampled in cycle n -> FRAME_DONE high in cycle n+1 only. The FRAME_COUNT update and BUSY drop (if going IDLE) are visible in n+1.
- START in cycle n -> BUSY=1 in n+1.
- A rise in the same cycle as START is not captured; capture waits for the next rise.
- ABORT in cycle n -> WR_EN=0 and BUSY=0 from n+1, including any in-flight write from an accepted pixel in cycle n.
- Fall and ABORT in the same cycle -> ABORT semantics only.

## Configuration
- CAPTURE_SEQ_ROI_EN defined: a pixel is in-window iff ROI_X0<=col<=ROI_X1 and ROI_Y0<=line<=ROI_Y1. If X0>X1 or Y0>Y1, no pixels are written, but FRAME_DONE still pulses.
- Not defined: ROI ports are present but ignored, and every valid pixel is in-window.

## Structure
- Package capture_pkg: state enum (IDLE, ARMED, CAPTURE, SKIP), PIX_W=10, FRAME_COUNT_W=16.
- Sub-module capture_roi_gate: registered-free window compare. It is instantiated only under CAPTURE_SEQ_ROI_EN; otherwise in-window is tied to 1.

## Test plan
- Single shot, H=8, V=4, no ROI, WR_READY=1: START, then one frame -> 32 writes with addresses 0..31 and data matching; one FRAME_DONE; FRAME_COUNT=1; BUSY=0 after.
- Continuous, DECIMATE=2, 9 frames -> frames 1, 4 and 7 captured; FRAME_COUNT=3. Drop CONTINUOUS during frame 7 -> IDLE after its fall.
- ROI X=2..4, Y=1..2 on 8x4 -> 6 writes, addresses 0..5, data from (col 2..4, line 1..2).
- WR_READY=0 for pixel 5 -> OVERFLOW=1; pixel 6 written at address 6. The next START clears OVERFLOW.
- ABORT mid-frame after 10 writes -> no further WR_EN, no FRAME_DONE, FRAME_COUNT unchanged. ABORT+START in the same cycle -> stays IDLE.
- Reset asserted mid-frame with FRAME_VALID=1, then START -> capture begins only at the next genuine rise.

Source files
------------

// File: rtl/capture_pkg.sv
// capture_pkg: types and constants shared by the capture sequencer.
//   state_t       - sequencer state (IDLE, ARMED, CAPTURE, SKIP)
//   PIX_W         - pixel data width
//   FRAME_COUNT_W - width of the completed-capture counter
//   DEC_W         - width of the frame-decimation count
package capture_pkg;

    localparam int PIX_W         = 10;
    localparam int FRAME_COUNT_W = 16;
    localparam int DEC_W         = 4;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        CAPTURE,
        SKIP
    } state_t;

endpackage

// File: rtl/capture_roi_gate.sv
// capture_roi_gate: combinational region-of-interest compare.
// Ports:
//   pix_col, pix_line  - coordinates of the current pixel
//   x0, x1             - inclusive column window
//   y0, y1             - inclusive line window
//   in_win             - 1 when the pixel lies inside both windows
// An inverted window (x0>x1 or y0>y1) never matches, so nothing is written.
module capture_roi_gate
    import capture_pkg::*;
#(
    parameter int H = 752,
    parameter int V = 480
) (
    input  logic [$clog2(H)-1:0] pix_col,
    input  logic [$clog2(V)-1:0] pix_line,
    input  logic [$clog2(H)-1:0] x0,
    input  logic [$clog2(H)-1:0] x1,
    input  logic [$clog2(V)-1:0] y0,
    input  logic [$clog2(V)-1:0] y1,
    output logic                 in_win
);

    assign in_win = (pix_col  >= x0) && (pix_col  <= x1) &&
                    (pix_line >= y0) && (pix_line <= y1);

endmodule

// File: rtl/capture_sequencer.sv
// capture_sequencer: sequences frame capture from the camera pixel stream
// into a linear frame-buffer write port.
// Optional build macro: CAPTURE_SEQ_ROI_EN (enables the ROI window; without
// it the ROI ports are ignored and every valid pixel is written).
// Ports:
//   PIXCLK, RST_N       - pixel clock, synchronous active-low reset
//   FRAME_VALID         - raw sensor frame strobe (edges detected internally)
//   PIXEL_VALID, DATA_IN, CURRENT_LINE, CURRENT_COLUMN - pixel stream
//   START, ABORT        - one-cycle capture request / cancel
//   CONTINUOUS, DECIMATE- continuous mode and frames skipped between captures
//   ROI_X0..ROI_Y1      - inclusive capture window (ROI build only)
//   WR_READY            - memory writer accepts the write presented this cycle
//   WR_EN/WR_ADDR/WR_DATA - registered write port
//   BUSY, FRAME_DONE, FRAME_COUNT, OVERFLOW - status
module capture_sequencer
    import capture_pkg::*;
#(
    parameter int H  = 752,
    parameter int V  = 480,
    parameter int AW = $clog2(H*V)
) (
    input  logic                     PIXCLK,
    input  logic                     RST_N,
    input  logic                     FRAME_VALID,
    input  logic                     PIXEL_VALID,
    input  logic [PIX_W-1:0]         DATA_IN,
    input  logic [$clog2(V)-1:0]     CURRENT_LINE,
    input  logic [$clog2(H)-1:0]     CURRENT_COLUMN,
    input  logic                     START,
    input  logic                     CONTINUOUS,
    input  logic [DEC_W-1:0]         DECIMATE,
    input  logic                     ABORT,
    input  logic [$clog2(H)-1:0]     ROI_X0,
    input  logic [$clog2(H)-1:0]     ROI_X1,
    input  logic [$clog2(V)-1:0]     ROI_Y0,
    input  logic [$clog2(V)-1:0]     ROI_Y1,
    input  logic                     WR_READY,
    output logic                     WR_EN,
    output logic [AW-1:0]            WR_ADDR,
    output logic [PIX_W-1:0]         WR_DATA,
    output logic                     BUSY,
    output logic                     FRAME_DONE,
    output logic [FRAME_COUNT_W-1:0] FRAME_COUNT,
    output logic                     OVERFLOW
);

    localparam logic [AW-1:0] ADDR_MAX = AW'(H*V-1);

    state_t             state;
    logic               prev_fv;
    logic [AW-1:0]      addr_cnt;
    logic [DEC_W-1:0]   skip_cnt;
    logic               in_win;
    logic               rise;
    logic               fall;

    assign rise = FRAME_VALID && !prev_fv;
    assign fall = !FRAME_VALID && prev_fv;

`ifdef CAPTURE_SEQ_ROI_EN
    capture_roi_gate #(.H(H), .V(V)) u_roi (
        .pix_col  (CURRENT_COLUMN),
        .pix_line (CURRENT_LINE),
        .x0       (ROI_X0),
        .x1       (ROI_X1),
        .y0       (ROI_Y0),
        .y1       (ROI_Y1),
        .in_win   (in_win)
    );
`else
    logic unused_roi;
    assign unused_roi = ^{ROI_X0, ROI_X1, ROI_Y0, ROI_Y1, CURRENT_LINE, CURRENT_COLUMN};
    assign in_win     = 1'b1;
`endif

    always_ff @(posedge PIXCLK) begin
        if (!RST_N) begin
            state       <= IDLE;
            prev_fv     <= 1'b1;   // a frame already running at reset is not a rise
            addr_cnt    <= '0;
            skip_cnt    <= '0;
            WR_EN       <= 1'b0;
            WR_ADDR     <= '0;
            WR_DATA     <= '0;
            BUSY        <= 1'b0;
            FRAME_DONE  <= 1'b0;
            FRAME_COUNT <= '0;
            OVERFLOW    <= 1'b0;
        end else begin
            prev_fv    <= FRAME_VALID;
            WR_EN      <= 1'b0;
            FRAME_DONE <= 1'b0;

            if (ABORT) begin
                // Cancels everything, including a pixel accepted this cycle.
                state <= IDLE;
                BUSY  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (START) begin
                            state    <= ARMED;
                            BUSY     <= 1'b1;
                            OVERFLOW <= 1'b0;
                        end
                    end
                    ARMED: begin
                        if (rise) begin
                            state    <= CAPTURE;
                            addr_cnt <= '0;
                        end
                    end
                    CAPTURE: begin
                        if (PIXEL_VALID && in_win) begin
                            WR_EN    <= 1'b1;
                            WR_ADDR  <= addr_cnt;
                            WR_DATA  <= DATA_IN;
                            // Saturate rather than wrap onto the start of the buffer.
                            if (addr_cnt != ADDR_MAX)
                                addr_cnt <= addr_cnt + 1'b1;
                        end
                        if (fall) begin
                            FRAME_DONE  <= 1'b1;
                            FRAME_COUNT <= FRAME_COUNT + 1'b1;
                            if (!CONTINUOUS) begin
                                state <= IDLE;
                                BUSY  <= 1'b0;
                            end else if (DECIMATE == '0) begin
                                state <= ARMED;
                            end else begin
                                state    <= SKIP;
                                skip_cnt <= DECIMATE;
                            end
                        end
                    end
                    SKIP: begin
                        if (fall) begin
                            skip_cnt <= skip_cnt - 1'b1;
                            if (skip_cnt == DEC_W'(1))
                                state <= ARMED;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        BUSY  <= 1'b0;
                    end
                endcase
            end

            // A write presented while the writer is stalled is lost. Placed last
            // so a drop in the same cycle as a START still registers.
            if (WR_EN && !WR_READY)
                OVERFLOW <= 1'b1;
        end
    end

endmodule

// File: tb/tb_capture_sequencer.sv
module tb_capture_sequencer;
    import capture_pkg::*;

    localparam int H    = 8;
    localparam int V    = 4;
    localparam int AW   = $clog2(H*V);
    localparam int NPIX = H*V;

    logic                     PIXCLK;
    logic                     RST_N;
    logic                     FRAME_VALID;
    logic                     PIXEL_VALID;
    logic [PIX_W-1:0]         DATA_IN;
    logic [$clog2(V)-1:0]     CURRENT_LINE;
    logic [$clog2(H)-1:0]     CURRENT_COLUMN;
    logic                     START;
    logic                     CONTINUOUS;
    logic [DEC_W-1:0]         DECIMATE;
    logic                     ABORT;
    logic [$clog2(H)-1:0]     ROI_X0, ROI_X1;
    logic [$clog2(V)-1:0]     ROI_Y0, ROI_Y1;
    logic                     WR_READY;
    logic                     WR_EN;
    logic [AW-1:0]            WR_ADDR;
    logic [PIX_W-1:0]         WR_DATA;
    logic                     BUSY;
    logic                     FRAME_DONE;
    logic [FRAME_COUNT_W-1:0] FRAME_COUNT;
    logic                     OVERFLOW;

    capture_sequencer #(.H(H), .V(V)) dut (
        .PIXCLK(PIXCLK), .RST_N(RST_N), .FRAME_VALID(FRAME_VALID), .PIXEL_VALID(PIXEL_VALID),
        .DATA_IN(DATA_IN), .CURRENT_LINE(CURRENT_LINE), .CURRENT_COLUMN(CURRENT_COLUMN),
        .START(START), .CONTINUOUS(CONTINUOUS), .DECIMATE(DECIMATE), .ABORT(ABORT),
        .ROI_X0(ROI_X0), .ROI_X1(ROI_X1), .ROI_Y0(ROI_Y0), .ROI_Y1(ROI_Y1),
        .WR_READY(WR_READY), .WR_EN(WR_EN), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA),
        .BUSY(BUSY), .FRAME_DONE(FRAME_DONE), .FRAME_COUNT(FRAME_COUNT), .OVERFLOW(OVERFLOW)
    );

    initial begin
        PIXCLK = 1'b0;
        forever #5 PIXCLK = ~PIXCLK;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;
    bit rand_ready = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    // Mode of the capture process as the spec describes it.
    localparam int M_IDLE = 0, M_ARMED = 1, M_CAP = 2, M_SKIP = 3;
    int m_mode, m_addr, m_skip;
    bit m_prev_fv, m_rise, m_fall, m_drop;
    bit e_wr_en, e_busy, e_done, e_ovf;
    int e_addr, e_data, e_count;

    function automatic bit pixel_in_window();
`ifdef CAPTURE_SEQ_ROI_EN
        return (int'(CURRENT_COLUMN) >= int'(ROI_X0)) && (int'(CURRENT_COLUMN) <= int'(ROI_X1)) &&
               (int'(CURRENT_LINE)   >= int'(ROI_Y0)) && (int'(CURRENT_LINE)   <= int'(ROI_Y1));
`else
        return 1'b1;
`endif
    endfunction

    initial begin
        forever begin
            @(posedge PIXCLK);
            if (!RST_N) begin
                m_mode = M_IDLE; m_addr = 0; m_skip = 0; m_prev_fv = 1'b1;
                e_wr_en = 0; e_busy = 0; e_done = 0; e_ovf = 0;
                e_addr = 0; e_data = 0; e_count = 0;
            end else begin
                m_rise    = FRAME_VALID && !m_prev_fv;
                m_fall    = !FRAME_VALID && m_prev_fv;
                m_prev_fv = FRAME_VALID;
                m_drop    = e_wr_en && !WR_READY;
                e_wr_en   = 0;
                e_done    = 0;
                if (ABORT) m_mode = M_IDLE;
                else if (m_mode == M_IDLE) begin
                    if (START) begin m_mode = M_ARMED; e_ovf = 0; end
                end else if (m_mode == M_ARMED) begin
                    if (m_rise) begin m_mode = M_CAP; m_addr = 0; end
                end else if (m_mode == M_CAP) begin
                    if (PIXEL_VALID && pixel_in_window()) begin
                        e_wr_en = 1; e_addr = m_addr; e_data = int'(DATA_IN);
                        m_addr  = (m_addr + 1 > NPIX - 1) ? NPIX - 1 : m_addr + 1;
                    end
                    if (m_fall) begin
                        e_done  = 1;
                        e_count = (e_count + 1) % 65536;
                        if (!CONTINUOUS)      m_mode = M_IDLE;
                        else if (DECIMATE == 0) m_mode = M_ARMED;
                        else begin m_mode = M_SKIP; m_skip = int'(DECIMATE); end
                    end
                end else begin
                    if (m_fall) begin
                        if (m_skip == 1) m_mode = M_ARMED;
                        m_skip = m_skip - 1;
                    end
                end
                if (m_drop) e_ovf = 1;
                e_busy = (m_mode != M_IDLE);
            end
        end
    end

    // ---------------- compare process + write log ----------------
    int addr_log[$];
    bit acc_log[$];
    int done_seen = 0;

    initial begin
        forever begin
            @(negedge PIXCLK);
            if (chk_en) begin
                chk("wr_en", 32'(WR_EN), 32'(e_wr_en));
                chk("busy", 32'(BUSY), 32'(e_busy));
                chk("frame_done", 32'(FRAME_DONE), 32'(e_done));
                chk("frame_count", 32'(FRAME_COUNT), 32'(e_count));
                chk("overflow", 32'(OVERFLOW), 32'(e_ovf));
                if (e_wr_en) begin
                    chk("wr_addr", 32'(WR_ADDR), 32'(e_addr));
                    chk("wr_data", 32'(WR_DATA), 32'(e_data));
                end
                if (WR_EN === 1'b1) begin
                    addr_log.push_back(int'(WR_ADDR));
                    acc_log.push_back(WR_READY);
                end
                if (FRAME_DONE === 1'b1) done_seen++;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge PIXCLK);
        #1;
        if (rand_ready) WR_READY = ($urandom % 4) != 0;
    endtask

    task automatic do_reset();
        RST_N = 1'b0; START = 0; ABORT = 0;
        tick(); tick();
        RST_N = 1'b1;
    endtask

    task automatic pulse_start();
        START = 1'b1; tick(); START = 1'b0;
    endtask

    task automatic pulse_abort();
        ABORT = 1'b1; tick(); ABORT = 1'b0;
    endtask

    // One frame: rise cycle without pixels, raster of pixels, line blanking, fall.
    task automatic run_frame(input int drop_idx, input int abort_idx, input int cont_clr_idx,
                             input bit gaps, input bit start_at_rise);
        FRAME_VALID = 1'b1; PIXEL_VALID = 1'b0;
        if (start_at_rise) START = 1'b1;
        tick();
        START = 1'b0;
        tick();
        for (int l = 0; l < V; l++) begin
            for (int c = 0; c < H; c++) begin
                int idx;
                idx = l * H + c;
                if (gaps && ($urandom % 4 == 0)) begin
                    PIXEL_VALID = 1'b0; tick();
                end
                PIXEL_VALID    = 1'b1;
                DATA_IN        = PIX_W'($urandom_range(0, 1023));
                CURRENT_LINE   = l[$clog2(V)-1:0];
                CURRENT_COLUMN = c[$clog2(H)-1:0];
                if (!rand_ready) WR_READY = (idx == drop_idx + 1) ? 1'b0 : 1'b1;
                ABORT = (idx == abort_idx);
                if (idx == cont_clr_idx) CONTINUOUS = 1'b0;
                tick();
                ABORT = 1'b0;
            end
            PIXEL_VALID = 1'b0; tick();
        end
        FRAME_VALID = 1'b0;
        tick(); tick(); tick();
        if (!rand_ready) WR_READY = 1'b1;
    endtask

    int b, d, c0;
    int frame_wr[1:9];

    initial begin
        RST_N = 0; FRAME_VALID = 0; PIXEL_VALID = 0; DATA_IN = '0;
        CURRENT_LINE = '0; CURRENT_COLUMN = '0; START = 0; CONTINUOUS = 0;
        DECIMATE = '0; ABORT = 0; WR_READY = 1;
        ROI_X0 = '0; ROI_X1 = $clog2(H)'(H-1); ROI_Y0 = '0; ROI_Y1 = $clog2(V)'(V-1);
        tick();
        chk_en = 1'b1;
        tick();
        chk("rst_wr_en", 32'(WR_EN), 0);
        chk("rst_busy", 32'(BUSY), 0);
        chk("rst_done", 32'(FRAME_DONE), 0);
        chk("rst_count", 32'(FRAME_COUNT), 0);
        chk("rst_ovf", 32'(OVERFLOW), 0);
        chk("rst_addr", 32'(WR_ADDR), 0);
        chk("rst_data", 32'(WR_DATA), 0);
        RST_N = 1'b1;
        tick();

        // single shot
        pulse_start();
        chk("start_busy", 32'(BUSY), 1);
        b = addr_log.size(); d = done_seen;
        run_frame(-2, -1, -1, 0, 0);
        chk("ss_writes", addr_log.size() - b, 32);
        chk("ss_first_addr", addr_log[b], 0);
        chk("ss_last_addr", addr_log[addr_log.size()-1], 31);
        chk("ss_done", done_seen - d, 1);
        chk("ss_count", 32'(FRAME_COUNT), 1);
        chk("ss_busy_after", 32'(BUSY), 0);

        // START coincident with rise: that frame is skipped
        do_reset();
        b = addr_log.size();
        run_frame(-2, -1, -1, 0, 1);
        chk("sr_writes", addr_log.size() - b, 0);
        chk("sr_busy", 32'(BUSY), 1);
        b = addr_log.size();
        run_frame(-2, -1, -1, 1, 0);
        chk("sr_next_writes", addr_log.size() - b, 32);

        // continuous with decimation 2, stop during frame 7
        do_reset();
        CONTINUOUS = 1; DECIMATE = 4'd2;
        pulse_start();
        d = done_seen;
        for (int f = 1; f <= 9; f++) begin
            b = addr_log.size();
            run_frame(-2, -1, (f == 7) ? 5 : -1, 0, 0);
            frame_wr[f] = addr_log.size() - b;
        end
        for (int f = 1; f <= 9; f++)
            chk($sformatf("cont_frame%0d_writes", f), frame_wr[f], (f == 1 || f == 4 || f == 7) ? 32 : 0);
        chk("cont_done", done_seen - d, 3);
        chk("cont_count", 32'(FRAME_COUNT), 3);
        chk("cont_busy_after", 32'(BUSY), 0);
        DECIMATE = '0;

        // backpressure on pixel 5
        do_reset();
        pulse_start();
        b = addr_log.size();
        run_frame(5, -1, -1, 0, 0);
        chk("bp_writes", addr_log.size() - b, 32);
        chk("bp_drop5", 32'(acc_log[b+5]), 0);
        chk("bp_addr6", addr_log[b+6], 6);
        chk("bp_acc6", 32'(acc_log[b+6]), 1);
        chk("bp_overflow", 32'(OVERFLOW), 1);
        pulse_start();
        chk("bp_ovf_cleared", 32'(OVERFLOW), 0);
        pulse_abort();

        // abort after 10 writes, then ABORT+START together
        do_reset();
        pulse_start();
        b = addr_log.size(); d = done_seen;
        run_frame(-2, 10, -1, 0, 0);
        chk("ab_writes", addr_log.size() - b, 10);
        chk("ab_done", done_seen - d, 0);
        chk("ab_count", 32'(FRAME_COUNT), 0);
        chk("ab_busy", 32'(BUSY), 0);
        ABORT = 1; START = 1; tick(); ABORT = 0; START = 0;
        chk("ab_start_busy", 32'(BUSY), 0);
        tick();
        chk("ab_start_busy2", 32'(BUSY), 0);

        // reset while a frame is in progress
        FRAME_VALID = 1'b1;
        do_reset();
        pulse_start();
        b = addr_log.size(); d = done_seen;
        for (int i = 0; i < 12; i++) begin
            PIXEL_VALID = 1'b1; DATA_IN = PIX_W'($urandom_range(0, 1023)); tick();
        end
        PIXEL_VALID = 1'b0; FRAME_VALID = 1'b0; tick(); tick();
        chk("rm_writes", addr_log.size() - b, 0);
        chk("rm_done", done_seen - d, 0);
        chk("rm_busy", 32'(BUSY), 1);
        run_frame(-2, -1, -1, 0, 0);
        chk("rm_next_writes", addr_log.size() - b, 32);
        chk("rm_next_done", done_seen - d, 1);

`ifdef CAPTURE_SEQ_ROI_EN
        do_reset();
        ROI_X0 = 3'd2; ROI_X1 = 3'd4; ROI_Y0 = 2'd1; ROI_Y1 = 2'd2;
        pulse_start();
        b = addr_log.size();
        run_frame(-2, -1, -1, 1, 0);
        chk("roi_writes", addr_log.size() - b, 6);
        chk("roi_last_addr", addr_log[addr_log.size()-1], 5);
        ROI_X0 = 3'd5; ROI_X1 = 3'd1;
        pulse_start();
        b = addr_log.size(); d = done_seen;
        run_frame(-2, -1, -1, 0, 0);
        chk("roi_inv_writes", addr_log.size() - b, 0);
        chk("roi_inv_done", done_seen - d, 1);
        ROI_X0 = '0; ROI_X1 = 3'd7; ROI_Y0 = '0; ROI_Y1 = 2'd3;
`endif

        // randomized traffic, checked cycle by cycle against the model
        do_reset();
        rand_ready = 1'b1;
        for (int it = 0; it < 24; it++) begin
            CONTINUOUS = 1'($urandom % 2);
            DECIMATE   = DEC_W'($urandom % 3);
`ifdef CAPTURE_SEQ_ROI_EN
            ROI_X0 = 3'($urandom % H); ROI_X1 = 3'($urandom % H);
            ROI_Y0 = 2'($urandom % V); ROI_Y1 = 2'($urandom % V);
`endif
            if ($urandom % 2) pulse_start();
            run_frame(-2, ($urandom % 6 == 0) ? int'($urandom % NPIX) : -1, -1, 1, ($urandom % 5) == 0);
        end
        rand_ready = 1'b0;
        WR_READY = 1'b1;
        tick(); tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
